// File: rtl/prog_clk_divider.sv
// Runtime-programmable integer clock divider with a 50%-duty output for odd and even ratios.
// Optional tick_o period-start pulse is enabled by defining PCD_TICK_OUT_EN.
module prog_clk_divider #(
    parameter int CNT_W     = 8,
    parameter int RATIO_RST = 5
) (
    input  logic             clk,
    input  logic             arstn,
    input  logic             en_i,
    input  logic [CNT_W-1:0] ratio_i,
    input  logic             ratio_wr,
    output logic             clk_out,
    output logic             running,
    output logic             upd_pend,
`ifdef PCD_TICK_OUT_EN
    output logic             ratio_err,
    output logic             tick_o
`else
    output logic             ratio_err
`endif
);

    typedef enum logic {IDLE, RUN} state_t;

    localparam logic [CNT_W-1:0] RST_RATIO = CNT_W'(RATIO_RST);
    localparam logic [CNT_W-1:0] ONE       = CNT_W'(1);
    localparam logic [CNT_W-1:0] TWO       = CNT_W'(2);
    localparam logic [CNT_W:0]   ONE_W     = (CNT_W+1)'(1);

    state_t           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [CNT_W-1:0] act_q, act_d;
    logic [CNT_W-1:0] pend_q, pend_d;
    logic             p_q, p_d;
    logic             n_q;
    logic             upd_pend_q, upd_pend_d;
    logic             ratio_err_q, ratio_err_d;

    logic [CNT_W:0]   hi_sum;
    logic [CNT_W:0]   hi;
    logic [CNT_W:0]   cnt_inc;
    logic             boundary;

    // hi is computed one bit wider so that act = 2^CNT_W-1 does not wrap
    assign hi_sum   = {1'b0, act_q} + ONE_W;
    assign hi       = hi_sum >> 1;
    assign cnt_inc  = {1'b0, cnt_q} + ONE_W;
    assign boundary = (cnt_q == (act_q - ONE));

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        act_d       = act_q;
        pend_d      = pend_q;
        p_d         = p_q;
        upd_pend_d  = upd_pend_q;
        ratio_err_d = ratio_err_q;

        case (state_q)
            IDLE: begin
                cnt_d = '0;
                p_d   = 1'b0;
                if (en_i) begin
                    act_d      = pend_q;
                    upd_pend_d = 1'b0;
                    p_d        = 1'b1;
                    state_d    = RUN;
                end
            end
            RUN: begin
                if (!boundary) begin
                    cnt_d = cnt_inc[CNT_W-1:0];
                    p_d   = (cnt_inc < hi);
                end else if (en_i) begin
                    cnt_d      = '0;
                    act_d      = pend_q;
                    upd_pend_d = 1'b0;
                    p_d        = 1'b1;
                end else begin
                    cnt_d   = '0;
                    p_d     = 1'b0;
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase

        // A write overrides the clear done by a period start in the same cycle
        if (ratio_wr) begin
            pend_d     = (ratio_i < TWO) ? TWO : ratio_i;
            upd_pend_d = 1'b1;
            if (ratio_i < TWO) begin
                ratio_err_d = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge arstn) begin
        if (!arstn) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            act_q       <= RST_RATIO;
            pend_q      <= RST_RATIO;
            p_q         <= 1'b0;
            upd_pend_q  <= 1'b0;
            ratio_err_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            act_q       <= act_d;
            pend_q      <= pend_d;
            p_q         <= p_d;
            upd_pend_q  <= upd_pend_d;
            ratio_err_q <= ratio_err_d;
        end
    end

    // Half-cycle delayed copy used to trim odd-ratio high time
    always_ff @(negedge clk or negedge arstn) begin
        if (!arstn) begin
            n_q <= 1'b0;
        end else begin
            n_q <= p_q;
        end
    end

`ifdef PCD_TICK_OUT_EN
    logic tick_q, tick_d;

    // Only a period start leaves RUN with a zero count
    always_comb begin
        tick_d = (state_d == RUN) && (cnt_d == '0);
    end

    always_ff @(posedge clk or negedge arstn) begin
        if (!arstn) begin
            tick_q <= 1'b0;
        end else begin
            tick_q <= tick_d;
        end
    end

    assign tick_o = tick_q;
`endif

    assign clk_out   = act_q[0] ? (p_q & n_q) : p_q;
    assign running   = (state_q == RUN);
    assign upd_pend  = upd_pend_q;
    assign ratio_err = ratio_err_q;

endmodule

// File: tb/tb_prog_clk_divider.sv
// Bench for prog_clk_divider: directed steps plus random writes/enables against a
// waveform-queue reference model checked every half clock cycle.
module tb_prog_clk_divider;

    logic       clk = 1'b0;
    logic       arstn;
    logic       en_i;
    logic [7:0] ratio_i;
    logic       ratio_wr;
    logic       clk_out;
    logic       running;
    logic       upd_pend;
    logic       ratio_err;
`ifdef PCD_TICK_OUT_EN
    logic       tick_o;
`endif

    int total = 0;
    int bad   = 0;

    // Reference model: a queue of expected clk_out levels, one entry per half cycle
    bit m_run;
    int m_act;
    int m_pend;
    bit m_upd;
    bit m_err;
    bit m_tick;
    bit m_q[$];
    bit last_lo;

    always #5 clk = ~clk;

    prog_clk_divider #(.CNT_W(8), .RATIO_RST(5)) dut (
        .clk       (clk),
        .arstn     (arstn),
        .en_i      (en_i),
        .ratio_i   (ratio_i),
        .ratio_wr  (ratio_wr),
        .clk_out   (clk_out),
        .running   (running),
        .upd_pend  (upd_pend),
`ifdef PCD_TICK_OUT_EN
        .ratio_err (ratio_err),
        .tick_o    (tick_o)
`else
        .ratio_err (ratio_err)
`endif
    );

    task automatic chk(input string tag, input logic obs, input logic exp_v);
        total++;
        assert (obs === exp_v) else begin
            bad++;
            $error("FAIL %s observed=%0b expected=%0b t=%0t", tag, obs, exp_v, $time);
        end
    endtask

    function automatic void model_reset();
        m_run  = 1'b0;
        m_q.delete();
        m_act  = 5;
        m_pend = 5;
        m_upd  = 1'b0;
        m_err  = 1'b0;
        m_tick = 1'b0;
    endfunction

    // Odd N: the output is high for N half cycles, delayed by one half cycle
    function automatic void push_period(input int n);
        if (n % 2 == 1) begin
            m_q.push_back(1'b0);
            repeat (n) m_q.push_back(1'b1);
            repeat (n - 1) m_q.push_back(1'b0);
        end else begin
            repeat (n) m_q.push_back(1'b1);
            repeat (n) m_q.push_back(1'b0);
        end
    endfunction

    function automatic void start_period();
        m_act  = m_pend;
        m_upd  = 1'b0;
        push_period(m_act);
        m_run  = 1'b1;
        m_tick = 1'b1;
    endfunction

    // One clock: entered and left at negedge+2 so inputs are stable across posedge
    task automatic cycle();
        bit e;
        bit w;
        int r;
        bit hi_exp;
        bit lo_exp;
        e = en_i;
        w = ratio_wr;
        r = int'(ratio_i);
        @(posedge clk);
        m_tick = 1'b0;
        if (m_run && m_q.size() == 0) begin
            if (e) start_period();
            else   m_run = 1'b0;
        end else if (!m_run && e) begin
            start_period();
        end
        if (m_run) begin
            hi_exp = m_q.pop_front();
            lo_exp = m_q.pop_front();
        end else begin
            hi_exp = 1'b0;
            lo_exp = 1'b0;
        end
        if (w) begin
            m_pend = (r < 2) ? 2 : r;
            m_upd  = 1'b1;
            if (r < 2) m_err = 1'b1;
        end
        #2;
        chk("clk_out_hi_half", clk_out, hi_exp);
        chk("running", running, m_run);
        chk("upd_pend", upd_pend, m_upd);
        chk("ratio_err", ratio_err, m_err);
`ifdef PCD_TICK_OUT_EN
        chk("tick_o", tick_o, m_tick);
`endif
        @(negedge clk);
        #2;
        chk("clk_out_lo_half", clk_out, lo_exp);
        last_lo = lo_exp;
    endtask

    task automatic run(input int n);
        repeat (n) cycle();
    endtask

    task automatic wr(input int r);
        ratio_i  = 8'(r);
        ratio_wr = 1'b1;
        cycle();
        ratio_wr = 1'b0;
        $display("write ratio=%0d pend=%0d act=%0d t=%0t", r, m_pend, m_act, $time);
    endtask

    task automatic wait_boundary();
        int k;
        k = 0;
        while (!(m_run && m_q.size() == 0) && k < 600) begin
            cycle();
            k++;
        end
        if (k >= 600) begin
            total++;
            bad++;
            $error("FAIL wait_boundary observed=timeout expected=boundary t=%0t", $time);
        end
    endtask

    initial begin
        arstn    = 1'b0;
        en_i     = 1'b0;
        ratio_i  = 8'd0;
        ratio_wr = 1'b0;
        last_lo  = 1'b0;
        model_reset();
        #3;
        chk("rst_clk_out", clk_out, 1'b0);
        chk("rst_running", running, 1'b0);
        chk("rst_upd_pend", upd_pend, 1'b0);
        chk("rst_ratio_err", ratio_err, 1'b0);
`ifdef PCD_TICK_OUT_EN
        chk("rst_tick_o", tick_o, 1'b0);
`endif
        #9;
        arstn = 1'b1;
        en_i  = 1'b1;

        $display("step default ratio 5");
        run(12);

        $display("step ratio 4/8/2");
        wr(4);  run(10);
        wr(8);  run(20);
        wr(2);  run(8);

        $display("step overwrite 7 then 3, boundary write");
        wr(7);  wr(3);  run(10);
        wait_boundary();
        wr(6);  run(14);

        $display("step stop with N=6");
        wait_boundary();
        cycle();
        en_i = 1'b0;
        run(14);
        en_i = 1'b1;
        run(14);

        $display("step illegal ratios and 255");
        wr(0);  run(8);
        wr(1);  run(8);
        wr(255); run(520);

        $display("step async reset in high phase");
        begin
            int k;
            k = 0;
            while (!last_lo && k < 600) begin
                cycle();
                k++;
            end
            if (k >= 600) begin
                total++;
                bad++;
                $error("FAIL wait_high observed=timeout expected=high t=%0t", $time);
            end
        end
        #1;
        arstn = 1'b0;
        #1;
        chk("arst_clk_out", clk_out, 1'b0);
        chk("arst_running", running, 1'b0);
        chk("arst_upd_pend", upd_pend, 1'b0);
        chk("arst_ratio_err", ratio_err, 1'b0);
        model_reset();
        @(negedge clk);
        #2;
        arstn = 1'b1;
        run(16);

        $display("step random");
        for (int i = 0; i < 1500; i++) begin
            if ($urandom_range(0, 39) == 0) en_i = ~en_i;
            if ($urandom_range(0, 9) == 0) begin
                ratio_i  = ($urandom_range(0, 3) == 0) ? 8'($urandom_range(0, 1))
                                                        : 8'($urandom_range(2, 12));
                ratio_wr = 1'b1;
            end else begin
                ratio_wr = 1'b0;
            end
            cycle();
        end
        ratio_wr = 1'b0;
        en_i     = 1'b1;
        run(30);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
